mr_wb_sram: RTL
===============

Name: mr_wb_sram

Overview:
- Wishbone B4 pipelined-mode slave: on-chip word-addressed SRAM with byte-lane writes and fixed read/write response latency.
- Responder end of the bus driven by the core's load/store master; serves as data memory and as the bench target for the master's stall, ack and err handling.
- One request accepted per cycle, with up to LATENCY requests in flight.

Parameters:
- DEPTH, 1024, number of XLEN-bit words; word indices 0..DEPTH-1 are valid.
- LATENCY, 1, cycles from the request acceptance edge to the ack/err cycle; legal range 1..4.
- INIT_FILE, "", hex file loaded into the array at elaboration; empty means contents are uninitialised.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = in reset).
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  XLEN-XLEN_GRAN (30)  word address, bits [XLEN-1:XLEN_GRAN].
- sel_i  in  XLEN/8 (4)  byte-lane enables.
- dat_i  in  XLEN (32)  write data.
- ack_o  out  1  successful response.
- err_o  out  1  error response for an out-of-range address.
- stall_o  out  1  request not accepted this cycle.
- dat_o  out  XLEN (32)  read data; valid only while ack_o is high for a read.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - ack_o=0, err_o=0, stall_o=0, dat_o=0.
  - All pipeline valid bits cleared.
  - Array contents are not reset.
- Acceptance: a request is accepted at a rising edge where cyc_i & stb_i & !stall_o.
- Out-of-range check: addr_i >= DEPTH marks the request as an error.
- Write, accepted and in range: for each i with sel_i[i]=1, byte i of mem[addr_i] takes dat_i[8i+7:8i] at the acceptance edge. Lanes with sel_i[i]=0 are unchanged. sel_i=0 is a legal no-op write that is still acked.
- Read, accepted and in range: mem[addr_i] is sampled at the acceptance edge, after any write committed at earlier edges. sel_i is ignored for reads; the full word is returned.
- Out-of-range request: no array access, no write. It gets err_o instead of ack_o.
- Response pipeline: shift register of LATENCY stages. Each stage holds {valid, is_err, is_read, data}. Stage 0 loads at the acceptance edge; each stage advances every cycle.
- Response outputs, driven from the last stage:
  - ack_o = valid & !is_err & cyc_i.
  - err_o = valid & is_err & cyc_i.
  - dat_o = data while ack_o is high for a read, else 0.
- Timing: a request accepted at edge N responds in the cycle after edge N+LATENCY-1. LATENCY=1 gives ack in the cycle immediately after acceptance.
- Ordering and throughput: back-to-back requests give back-to-back acks, in order, one per cycle. No bubbles are inserted.
- Exclusivity: ack_o and err_o are never high in the same cycle.
- cyc_i low: all pipeline valid bits clear at the next edge, and ack_o/err_o are gated low in that same cycle (abort). Writes already committed remain committed.
- stb_i high with cyc_i low: ignored.
- Mid-transaction reset: pipeline is flushed immediately and outputs go to their reset values. Writes accepted before reset remain in the array.
- Read-after-write: a read of the same address accepted one cycle after a write returns the written data.

Optional Feature:
- Macro: MR_WB_SRAM_STALL_EN.
- With the macro defined, stall_o comes from an 8-bit Fibonacci LFSR:
  - Polynomial x^8+x^6+x^5+x^4+1.
  - Seeded to 8'hA5 on reset and advanced every cycle.
  - stall_o = lfsr[1] & lfsr[0], so the stall duty is about 25%.
  - stall_o is independent of stb_i.
  - While stall_o=1 no request is accepted; the master must hold its request.
  - Responses already in flight continue unaffected.
- Without the macro: stall_o is constant 0, and no LFSR logic exists.

Test Plan:
- LATENCY=1: write addr 0x10, dat 0xDEADBEEF, sel 4'b1111, then read addr 0x10 -> ack_o one cycle after each acceptance; read dat_o=0xDEADBEEF.
- Byte lanes: mem[5]=0x11223344, write dat 0xAABBCCDD with sel 4'b0101, then read -> 0x11BB33DD.
- LATENCY=3: four back-to-back reads of addrs 0..3 preloaded with 0xA0..0xA3 -> acks in 4 consecutive cycles starting 3 cycles after the first acceptance; data in order 0xA0..0xA3.
- DEPTH=1024: read addr 1024 -> err_o=1 for one cycle, ack_o=0, dat_o=0; a write to addr 2000 leaves the whole array unchanged.
- Abort: LATENCY=3, two reads issued, cyc_i dropped one cycle later -> no ack_o/err_o ever seen; a later read at addr 0 acks normally.
- With MR_WB_SRAM_STALL_EN: 64 random reads/writes against a reference model -> no request accepted while stall_o=1; acks equal the number of accepted requests; all data matches.

Source files
------------

// File: rtl/mr_wb_sram.sv
// Wishbone B4 pipelined slave: word-addressed SRAM with byte-lane writes and a fixed
// LATENCY-cycle response pipeline. Define MR_WB_SRAM_STALL_EN for LFSR-driven stall_o.
module mr_wb_sram #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [31:0] dat_o
);
  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;
  localparam int AW        = XLEN - XLEN_GRAN;
  localparam int SEL_W     = XLEN / 8;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic             accept;
  logic             in_range;
  logic             wr_en;
  logic [IDX_W-1:0] idx;

  logic [LATENCY-1:0] vld_p;
  logic               err_p [LATENCY];
  logic               rd_p  [LATENCY];
  logic [XLEN-1:0]    dat_p [LATENCY];

`ifdef MR_WB_SRAM_STALL_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, shifting towards the MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_o = lfsr[1] & lfsr[0];
`else
  assign stall_o = 1'b0;
`endif

  assign accept   = cyc_i & stb_i & ~stall_o;
  assign in_range = addr_i < DEPTH_A;
  assign idx      = addr_i[IDX_W-1:0];
  assign wr_en    = accept & we_i & in_range;

  // Stage p0: array write and read sample at the acceptance edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (wr_en && sel_i[i]) mem[idx][8*i +: 8] <= dat_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else if (!cyc_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Payload is qualified by vld_p, so it needs no reset
  always_ff @(posedge clk) begin
    err_p[0] <= ~in_range;
    rd_p[0]  <= ~we_i;
    dat_p[0] <= (in_range && !we_i) ? mem[idx] : '0;
    for (int s = 1; s < LATENCY; s++) begin
      err_p[s] <= err_p[s-1];
      rd_p[s]  <= rd_p[s-1];
      dat_p[s] <= dat_p[s-1];
    end
  end

  // Output stage: last pipeline slot, gated by cyc_i for abort
  assign ack_o = vld_p[LATENCY-1] & ~err_p[LATENCY-1] & cyc_i;
  assign err_o = vld_p[LATENCY-1] &  err_p[LATENCY-1] & cyc_i;
  assign dat_o = (ack_o && rd_p[LATENCY-1]) ? dat_p[LATENCY-1] : '0;

endmodule
